// File: rtl/rom_stream_pkg.sv
// Shared types and defaults for the ROM stream reader.
// Holds the sweep FSM encoding and the address wrap helper.
package rom_stream_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    function automatic int wrap_inc(input int a, input int depth);
        return (a == depth - 1) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream from the reader to its consumer.
interface rom_stream_reader_if
    import rom_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/rom_stream_fifo.sv
// Shift-style buffer: entry 0 is the head register driving the stream.
module rom_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] mem_nxt [DEPTH];
    logic [OCC_W-1:0] wr_idx;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != OCC_W'(DEPTH)) || do_pop);
    assign wr_idx  = do_pop ? occ - OCC_W'(1) : occ;
    assign valid   = occ != '0;
    assign dout    = mem[0];

    always_comb begin
        mem_nxt = mem;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == OCC_W'(i)) mem_nxt[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            occ <= '0;
        end else begin
            mem <= mem_nxt;
            occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Sweeps an address window through a registered ROM and streams the words.
// ROM_STREAM_READER_CHECKSUM_EN adds a running sum of accepted words.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    rom_stream_reader_if.master m
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [OCC_W:0]  FIFO_L  = (OCC_W+1)'(FIFO_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   remain;
    logic              inflight;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    fill;
    logic              pop;
    logic              issue;
    logic              accept;
    logic              bad;

    assign pop    = m.m_valid && m.m_ready;
    assign fill   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign accept = start && (state == IDLE);
    assign bad    = ({1'b0, base_addr} >= DEPTH_L) || (length > DEPTH_L);
    // A read may reuse the slot freed by a same-cycle pop.
    assign issue  = (state == ISSUE)
                 && ((fill < FIFO_L) || ((fill == FIFO_L) && pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && !bad)
                    state_nxt = (length == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (issue && (remain == (ADDR_W+1)'(1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight
                    && ((occ == '0) || ((occ == OCC_W'(1)) && pop)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        done     = state == DONE;
        rom_en   = issue;
        rom_addr = issue ? cur_addr : last_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            last_addr <= '0;
            remain    <= '0;
            inflight  <= 1'b0;
            err       <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                err <= bad;
                if (!bad) begin
                    cur_addr <= base_addr;
                    remain   <= length;
                end
            end else if (issue) begin
                cur_addr  <= ADDR_W'(wrap_inc(32'(cur_addr), DEPTH));
                remain    <= remain - (ADDR_W+1)'(1);
                last_addr <= cur_addr;
            end
        end
    end

    // The ROM output is only meaningful the cycle after a read.
    rom_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (rom_data),
        .pop   (pop),
        .valid (m.m_valid),
        .dout  (m.m_data),
        .occ   (occ)
    );

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              checksum <= '0;
        else if (accept && !bad) checksum <= '0;
        else if (pop)            checksum <= checksum + m.m_data;
    end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed vector bench for rom_stream_reader with a behavioural ROM.
module tb_rom_stream_reader;

    typedef struct {
        int base;
        int len;
        bit stall;
        bit poke;
        bit exp_err;
        int first;
        int sum;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] base_addr = 3'd0;
    logic [3:0] length = 4'd0;
    logic       busy;
    logic       done;
    logic       err;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic       m_ready = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] rom [8] = '{8'd10, 8'd13, 8'd40, 8'd50,
                            8'd20, 8'd100, 8'd130, 8'd0};

    rom_stream_reader_if bus ();
    assign bus.m_ready = m_ready;
    assign m_valid     = bus.m_valid;
    assign m_data      = bus.m_data;

    rom_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m         (bus)
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Registered ROM; garbage when not enabled.
    always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got [$];
    int         gcyc [$];
    logic [2:0] adq [$];
    int         vq [$];
    int         dcyc [$];
    int         fill_viol = 0;
    int         hold_viol = 0;
    int         stall_viol = 0;
    int         outst = 0;
    bit         acc;
    bit         prev_v = 1'b0;
    bit         prev_r = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic [2:0] last_a = 3'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            outst  = 0;
            prev_v = 1'b0;
            last_a = 3'd0;
        end else begin
            acc = m_valid && m_ready;
            if (rom_en && (outst - int'(acc)) >= 2) fill_viol++;
            if (!rom_en && rom_addr != last_a) hold_viol++;
            if (rom_en) begin
                last_a = rom_addr;
                adq.push_back(rom_addr);
            end
            if (prev_v && !prev_r && (!m_valid || m_data != prev_d))
                stall_viol++;
            if (m_valid && !prev_v) vq.push_back(cyc);
            if (acc) begin
                got.push_back(m_data);
                gcyc.push_back(cyc);
            end
            if (done) dcyc.push_back(cyc);
            outst  = outst + int'(rom_en) - int'(acc);
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string nm(input int i, input string s);
        return $sformatf("v%0d_%s", i, s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int g0, a0, d0, v0, sv0, fv0, hv0, s, k, wbad, abad, n;
        logic [2:0] idx;
        m_ready   = 1'b1;
        base_addr = 3'(v.base);
        length    = 4'(v.len);
        start     = 1'b1;
        g0  = got.size();
        a0  = adq.size();
        d0  = dcyc.size();
        v0  = vq.size();
        sv0 = stall_viol;
        fv0 = fill_viol;
        hv0 = hold_viol;
        step();
        start = 1'b0;
        s = cyc;
        if (v.exp_err) begin
            repeat (5) step();
            chk(nm(i, "err"), int'(err), 1);
            chk(nm(i, "busy"), int'(busy), 0);
            chk(nm(i, "done_cnt"), dcyc.size() - d0, 0);
            chk(nm(i, "en_cnt"), adq.size() - a0, 0);
            chk(nm(i, "words"), got.size() - g0, 0);
        end else begin
            k = 0;
            while (dcyc.size() == d0 && k < 100) begin
                m_ready = v.stall ? (k % 3 == 0) : 1'b1;
                if (v.poke && k == 3) begin
                    start     = 1'b1;
                    base_addr = 3'd7;
                    length    = 4'd8;
                end
                step();
                start = 1'b0;
                k++;
            end
            chk(nm(i, "in_time"), int'(k < 100), 1);
            m_ready = 1'b1;
            repeat (2) step();
            chk(nm(i, "done_cnt"), dcyc.size() - d0, 1);
            chk(nm(i, "err"), int'(err), 0);
            chk(nm(i, "busy"), int'(busy), 0);
            chk(nm(i, "en_cnt"), adq.size() - a0, v.len);
            chk(nm(i, "words"), got.size() - g0, v.len);
            n = got.size() - g0;
            wbad = 0;
            abad = 0;
            for (int j = 0; j < v.len; j++) begin
                idx = 3'((v.base + j) % 7);
                if (j >= n || got[g0+j] != rom[idx]) wbad++;
                if (j >= adq.size() - a0 || adq[a0+j] != idx) abad++;
            end
            chk(nm(i, "word_errs"), wbad, 0);
            chk(nm(i, "addr_errs"), abad, 0);
            if (v.len > 0 && n > 0)
                chk(nm(i, "first_word"), int'(got[g0]), v.first);
            chk(nm(i, "stall_viol"), stall_viol - sv0, 0);
            chk(nm(i, "fill_viol"), fill_viol - fv0, 0);
            chk(nm(i, "hold_viol"), hold_viol - hv0, 0);
            if (dcyc.size() > d0) begin
                if (v.len == 0)
                    chk(nm(i, "done_cyc"), dcyc[d0], s);
                else if (n > 0)
                    chk(nm(i, "done_cyc"), dcyc[d0], gcyc[g0+n-1] + 1);
            end
            if (!v.stall && v.len > 0 && n > 0 && vq.size() > v0) begin
                chk(nm(i, "latency"), vq[v0] - s, 2);
                chk(nm(i, "span"), gcyc[g0+n-1] - gcyc[g0], v.len - 1);
            end
`ifdef ROM_STREAM_READER_CHECKSUM_EN
            chk(nm(i, "checksum"), int'(checksum), v.sum);
`endif
        end
    endtask

    vec_t vecs [12];

    initial begin
        int g0, d0, k;
        vecs[0]  = '{2, 4, 0, 0, 0, 40, 210};
        vecs[1]  = '{5, 4, 0, 0, 0, 100, 253};
        vecs[2]  = '{0, 7, 1, 1, 0, 10, 107};
        vecs[3]  = '{0, 0, 0, 0, 0, -1, 0};
        vecs[4]  = '{7, 3, 0, 0, 1, -1, 0};
        vecs[5]  = '{1, 2, 1, 0, 0, 13, 53};
        vecs[6]  = '{0, 8, 0, 0, 1, -1, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 10, 10};
        vecs[8]  = '{6, 1, 1, 0, 0, 130, 130};
        vecs[9]  = '{3, 7, 1, 0, 0, 50, 107};
        vecs[10] = '{0, 3, 0, 0, 0, 10, 63};
        vecs[11] = '{4, 3, 1, 0, 0, 20, 250};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Sticky error cleared by asynchronous reset.
        run_vec(20, vecs[4]);
        rst_n = 1'b0;
        #1;
        chk("rst_clears_err", int'(err), 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a sweep.
        m_ready   = 1'b1;
        base_addr = 3'd0;
        length    = 4'd7;
        start     = 1'b1;
        g0 = got.size();
        d0 = dcyc.size();
        step();
        start = 1'b0;
        k = 0;
        while (got.size() < g0 + 2 && k < 50) begin
            step();
            k++;
        end
        chk("mid_progress", int'(k < 50), 1);
        chk("mid_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_rom_en", int'(rom_en), 0);
        chk("mid_rom_addr", int'(rom_addr), 0);
        chk("mid_m_valid", int'(m_valid), 0);
        chk("mid_m_data", int'(m_data), 0);
        repeat (3) step();
        chk("mid_no_done", dcyc.size() - d0, 0);
        rst_n = 1'b1;
        step();
        run_vec(30, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream controller for the registered 8-bit lookup ROM (1-cycle read latency, output undefined when its enable is low).
- On a start pulse it sweeps a programmed address window through the ROM and drives rom_en/rom_addr.
- It captures each returned word into a small FIFO and presents the words as a valid/ready stream to the downstream consumer.
- Throughput is one word per clock while the consumer keeps m_ready high.

Parameters:
ADDR_W, 3, ROM address width
DATA_W, 8, ROM word width
DEPTH, 7, number of populated ROM locations (0..DEPTH-1); sweep wraps DEPTH-1 -> 0
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
base_addr  in  ADDR_W  first address of sweep, sampled with start
length  in  ADDR_W+1  words to read (0..DEPTH), sampled with start
busy  out  1  high from accepted start until last word leaves m_data
done  out  1  one-cycle pulse when last word is accepted downstream
err  out  1  sticky; set if base_addr>=DEPTH or length>DEPTH at start; cleared by next accepted start
rom_en  out  1  ROM read enable, high only in cycles issuing a read
rom_addr  out  ADDR_W  ROM address; held at last value when rom_en low
rom_data  in  DATA_W  ROM registered output, valid the cycle after rom_en
m_valid  out  1  stream word valid
m_data  out  DATA_W  stream word
m_ready  in  1  downstream accept

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, rom_en=0, rom_addr=0, m_valid=0, m_data=0; FIFO empty, in-flight flag cleared. Reset mid-sweep discards all words, no done pulse.
- States: IDLE -> ISSUE on start (length!=0, no err condition); IDLE -> DONE directly on start with length=0 (done pulses next cycle, no reads, no stream words); error start -> err=1, stays IDLE, busy stays 0.
- ISSUE: read issued (rom_en=1, rom_addr=current) when occ + inflight < FIFO_DEPTH, or occ + inflight == FIFO_DEPTH with a pop this cycle. Address increments after each issue; DEPTH-1 wraps to 0. After the final issue -> DRAIN.
- inflight: registered flag, set the cycle after an issue. When set, rom_data is pushed into the FIFO that cycle. rom_data is never sampled otherwise, because the ROM returns X when rom_en is low.
- DRAIN: no issues; waits until FIFO empty and inflight=0 -> DONE.
- DONE: done=1 for one cycle, busy falls with it -> IDLE.
- Latency: first m_valid two cycles after the start cycle (issue at cycle 1, data registered at 2).
- Stream rules:
  - m_data/m_valid come straight from FIFO head registers.
  - Once m_valid is high, m_data is held stable until m_ready.
  - Words are delivered in address order, with no drops or duplicates.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- start while busy: ignored, no effect on err.

Optional Feature:
- ROM_STREAM_READER_CHECKSUM_EN
- Defined: adds output checksum [DATA_W-1:0], the modulo-2^DATA_W sum of all words accepted downstream in the current sweep. It clears on accepted start and is stable from the done pulse until the next start.
- Undefined: port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Package rom_stream_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), ADDR_W/DATA_W/DEPTH defaults, and a wrap-increment function.
- One natural sub-module: rom_stream_fifo, a synchronous FIFO_DEPTH-entry buffer with occ count, push/pop, and head-register output.

Test Plan:
- ROM={10,13,40,50,20,100,130}; start base=2 length=4, m_ready=1 -> m_data 40,50,20,100 on consecutive cycles; rom_en high 4 cycles; done once.
- base=5 length=4 -> wrap: 100,130,10,13; rom_addr sequence 5,6,0,1.
- base=0 length=7, m_ready toggling 1,0,0,1,... -> all 7 words in order. No issue ever makes occ+inflight exceed 2. m_data stays stable while stalled.
- length=0 -> done pulses, no m_valid, no rom_en. base=7 -> err=1, busy=0; next valid start clears err.
- rst_n low mid-sweep (after 2 words) -> all outputs to reset values asynchronously. A new sweep after release starts clean.
- CHECKSUM_EN defined, base=0 length=3 -> checksum=63 at done; base=4 length=3 -> (20+100+130) mod 256 = 250.
